// File: rtl/array_3d_pkg.sv
// Shared types and defaults for the 3-D array scan controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package array_3d_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Default array dimensions and write data width.
  localparam int DEF_DIM_I = 4;
  localparam int DEF_DIM_J = 3;
  localparam int DEF_DIM_K = 2;
  localparam int DEF_DW    = 32;

  // Index width for a range 0..n-1; never narrower than one bit so that a
  // dimension of 1 still has a (constant zero) index port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/array_3d_idx_cnt.sv
// Wrapping index counter 0..N-1 with increment enable and carry-out.
// Latency: idx updates one cycle after inc; carry is combinational from inc.
// Backpressure: none, the caller gates inc.
// Ports: clk, rst (sync, active high), clr (sync clear), inc, idx, carry.
module array_3d_idx_cnt
  import array_3d_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  carry
);

  localparam int W = idx_w(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  // For N=1 LAST is 0, so every increment carries and idx stays 0.
  assign carry = inc && (idx == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (inc) begin
      if (idx == LAST) idx <= '0;
      else             idx <= idx + W'(1);
    end
  end

endmodule

// File: rtl/array_3d_scan_ctrl.sv
// Scans a DIM_I x DIM_J x DIM_K index space (k fastest), one write per accepted beat.
// Latency: first write valid the cycle after start; done one cycle after last acceptance.
// Backpressure: wr_vld/wr_rdy handshake; index and data hold while wr_rdy is low.
// Ports: clk, rst (sync, active high), start, busy, done, wr_vld, wr_rdy,
//        wr_i/wr_j/wr_k, wr_dat; plus abort when ARRAY_3D_SCAN_CTRL_ABORT_EN is defined.
module array_3d_scan_ctrl
  import array_3d_pkg::*;
#(
  parameter int DIM_I = DEF_DIM_I,
  parameter int DIM_J = DEF_DIM_J,
  parameter int DIM_K = DEF_DIM_K,
  parameter int DW    = DEF_DW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
`ifdef ARRAY_3D_SCAN_CTRL_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     wr_vld,
  input  logic                     wr_rdy,
  output logic [idx_w(DIM_I)-1:0]  wr_i,
  output logic [idx_w(DIM_J)-1:0]  wr_j,
  output logic [idx_w(DIM_K)-1:0]  wr_k,
  output logic [DW-1:0]            wr_dat
);

  state_t state, state_nxt;
  logic   acc;
  logic   clr;
  logic   carry_k, carry_j, carry_i;

  // Acceptance is derived from the state register directly rather than from
  // wr_vld so the next-state logic has no path back into itself.
  assign acc = (state == ST_RUN) && wr_rdy;
  // Counters sit at zero outside RUN, so every scan starts at (0,0,0) even
  // after an abort left them mid-range.
  assign clr = (state != ST_RUN);

  array_3d_idx_cnt #(.N(DIM_K)) u_cnt_k (
    .clk(clk), .rst(rst), .clr(clr), .inc(acc),     .idx(wr_k), .carry(carry_k)
  );
  array_3d_idx_cnt #(.N(DIM_J)) u_cnt_j (
    .clk(clk), .rst(rst), .clr(clr), .inc(carry_k), .idx(wr_j), .carry(carry_j)
  );
  array_3d_idx_cnt #(.N(DIM_I)) u_cnt_i (
    .clk(clk), .rst(rst), .clr(clr), .inc(carry_j), .idx(wr_i), .carry(carry_i)
  );

  assign wr_dat = DW'(wr_i) + DW'(wr_j) + DW'(wr_k);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    wr_vld    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy   = 1'b1;
        wr_vld = 1'b1;
        // carry_i only fires on acceptance of the final element.
        if (carry_i) state_nxt = ST_DONE;
`ifdef ARRAY_3D_SCAN_CTRL_ABORT_EN
        else if (abort) state_nxt = ST_DONE;
`endif
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_array_3d_scan_ctrl.sv
// Directed bench for array_3d_scan_ctrl: default 4x3x2 instance plus a 1x1x5 instance.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Backpressure: wr_rdy stalls driven from the stimulus loop.
module tb_array_3d_scan_ctrl;

  localparam int DI = 4;
  localparam int DJ = 3;
  localparam int DK = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, wr_rdy;
  logic        busy, done, wr_vld;
  logic [1:0]  wr_i, wr_j;
  logic [0:0]  wr_k;
  logic [31:0] wr_dat;
`ifdef ARRAY_3D_SCAN_CTRL_ABORT_EN
  logic        abort;
`endif

  logic        start2, wr_rdy2;
  logic        busy2, done2, wr_vld2;
  logic [0:0]  wr_i2, wr_j2;
  logic [2:0]  wr_k2;
  logic [7:0]  wr_dat2;

  int n_checks = 0;
  int n_errors = 0;

  // Values of the first and last write observed in the most recent scan.
  logic [31:0] first_i, first_j, first_k, first_d;
  logic [31:0] last_i, last_j, last_k, last_d;

  array_3d_scan_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef ARRAY_3D_SCAN_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .wr_i(wr_i), .wr_j(wr_j), .wr_k(wr_k), .wr_dat(wr_dat)
  );

  array_3d_scan_ctrl #(.DIM_I(1), .DIM_J(1), .DIM_K(5), .DW(8)) u_dut5 (
    .clk(clk), .rst(rst), .start(start2),
`ifdef ARRAY_3D_SCAN_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy2), .done(done2), .wr_vld(wr_vld2), .wr_rdy(wr_rdy2),
    .wr_i(wr_i2), .wr_j(wr_j2), .wr_k(wr_k2), .wr_dat(wr_dat2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},   32'(busy),   0);
    check({tag, " done"},   32'(done),   0);
    check({tag, " wr_vld"}, 32'(wr_vld), 0);
    check({tag, " wr_i"},   32'(wr_i),   0);
    check({tag, " wr_j"},   32'(wr_j),   0);
    check({tag, " wr_k"},   32'(wr_k),   0);
    check({tag, " wr_dat"}, wr_dat,      0);
  endtask

  // Runs one scan on the default instance. stall_at: write number at which
  // wr_rdy drops for 3 cycles; restart_at: write number at which start is
  // pulsed again; reset_at: write number at which rst hits together with an
  // acceptance; abort_at: write number carrying abort; total: writes expected.
  task automatic run_scan(input int stall_at, input int restart_at, input int reset_at,
                          input int abort_at, input int total);
    int nwr = 0;
    int cyc = 0;
    int stalls = 0;
    int ei = 0, ej = 0, ek = 0;
    bit restarted = 0;
    bit acc;
    check("pre_start busy", 32'(busy), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (nwr < total && cyc < 400) begin
      check("run wr_vld", 32'(wr_vld), 1);
      check("run busy",   32'(busy),   1);
      check("run done",   32'(done),   0);
      check("run wr_i",   32'(wr_i),   32'(ei));
      check("run wr_j",   32'(wr_j),   32'(ej));
      check("run wr_k",   32'(wr_k),   32'(ek));
      check("run wr_dat", wr_dat,      32'(ei + ej + ek));
      wr_rdy = 1'b1;
      if (nwr == stall_at && stalls < 3) begin
        wr_rdy = 1'b0;
        stalls++;
      end
      if (nwr == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      if (nwr == reset_at) rst = 1'b1;
`ifdef ARRAY_3D_SCAN_CTRL_ABORT_EN
      if (nwr == abort_at) abort = 1'b1;
`endif
      acc = wr_rdy;
      tick();
      cyc++;
      start = 1'b0;
`ifdef ARRAY_3D_SCAN_CTRL_ABORT_EN
      abort = 1'b0;
`endif
      if (rst) begin
        rst = 1'b0;
        check_idle("after_rst");
        return;
      end
      if (acc) begin
        if (nwr == 0) begin
          first_i = 32'(ei); first_j = 32'(ej); first_k = 32'(ek); first_d = 32'(ei + ej + ek);
        end
        last_i = 32'(ei); last_j = 32'(ej); last_k = 32'(ek); last_d = 32'(ei + ej + ek);
        nwr++;
        ek++;
        if (ek == DK) begin
          ek = 0;
          ej++;
          if (ej == DJ) begin
            ej = 0;
            ei++;
          end
        end
      end
    end
    check("scan timeout", 32'(cyc < 400), 1);
    check("write count",  32'(nwr), 32'(total));
    if (stall_at >= 0) check("stall cycles", 32'(stalls), 3);
    if (restart_at >= 0) check("restart pulsed", 32'(restarted), 1);
    check("done pulse",   32'(done),   1);
    check("done wr_vld",  32'(wr_vld), 0);
    check("done busy",    32'(busy),   1);
    tick();
    check("post done",    32'(done),   0);
    check("post busy",    32'(busy),   0);
    check("post wr_vld",  32'(wr_vld), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wr_rdy = 1'b1;
    start2 = 1'b0; wr_rdy2 = 1'b1;
`ifdef ARRAY_3D_SCAN_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;
    repeat (3) tick();
    check("idle ignores nothing busy", 32'(busy), 0);

    // Plain scan, start at cycle 4 after reset.
    run_scan(-1, -1, -1, -1, 24);
    check("first i", first_i, 0);
    check("first j", first_j, 0);
    check("first k", first_k, 0);
    check("first dat", first_d, 0);
    check("last i", last_i, 3);
    check("last j", last_j, 2);
    check("last k", last_k, 1);
    check("last dat", last_d, 6);

    // Stall at write (1,1,0) = write 8, dat 2.
    tick();
    run_scan(8, -1, -1, -1, 24);
    check("stall last dat", last_d, 6);

    // Start re-pulsed mid-scan is ignored.
    tick();
    run_scan(-1, 10, -1, -1, 24);

    // Reset with a simultaneous acceptance at write 7.
    tick();
    run_scan(-1, -1, 7, -1, 24);
    repeat (2) tick();
    check("no resume busy",   32'(busy),   0);
    check("no resume wr_vld", 32'(wr_vld), 0);
    run_scan(-1, -1, -1, -1, 24);
    check("restart first k", first_k, 0);
    check("restart first i", first_i, 0);

`ifdef ARRAY_3D_SCAN_CTRL_ABORT_EN
    tick();
    run_scan(-1, -1, -1, 5, 6);
    check("abort last k", last_k, 1);
    check("abort last j", last_j, 2);
    check("abort last i", last_i, 0);
    // abort in IDLE is ignored
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle abort busy", 32'(busy), 0);
`endif

    // 1x1x5 instance: k walks 0..4, dat 0..4, then done.
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 0; n < 5; n++) begin
      check("d5 wr_vld", 32'(wr_vld2), 1);
      check("d5 wr_i",   32'(wr_i2),   0);
      check("d5 wr_j",   32'(wr_j2),   0);
      check("d5 wr_k",   32'(wr_k2),   32'(n));
      check("d5 wr_dat", 32'(wr_dat2), 32'(n));
      tick();
    end
    check("d5 done",   32'(done2),   1);
    check("d5 wr_vld done", 32'(wr_vld2), 0);
    tick();
    check("d5 post busy", 32'(busy2), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
